// File: rtl/musb_bus_arbiter.sv
// musb_bus_arbiter: three-master / one-slave round-robin bus arbiter with a
// bus watchdog. Master 0 is the bootloader/debug port, master 1 the core data
// port and master 2 the core instruction port. One transaction is granted at
// a time. The slave request and all completion responses are combinational
// passthroughs of the registered grant.
module musb_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned ENABLE_TIMEOUT = 1
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (bootloader / debug)
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data_i,
  input  logic        m0_wr,
  input  logic [3:0]  m0_byte_sel,
  input  logic        m0_enable,
  output logic [31:0] m0_data_o,
  output logic        m0_ready,
  output logic        m0_error,
  // master 1 (core data port)
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data_i,
  input  logic        m1_wr,
  input  logic [3:0]  m1_byte_sel,
  input  logic        m1_enable,
  output logic [31:0] m1_data_o,
  output logic        m1_ready,
  output logic        m1_error,
  // master 2 (core instruction port)
  input  logic [31:0] m2_address,
  input  logic [31:0] m2_data_i,
  input  logic        m2_wr,
  input  logic [3:0]  m2_byte_sel,
  input  logic        m2_enable,
  output logic [31:0] m2_data_o,
  output logic        m2_ready,
  output logic        m2_error,
  // shared slave port
  output logic [31:0] s_address,
  output logic [31:0] s_data_o,
  output logic        s_wr,
  output logic [3:0]  s_byte_sel,
  output logic        s_enable,
  input  logic [31:0] s_data_i,
  input  logic        s_ready,
  input  logic        s_error,
  // status
  output logic [2:0]  grant,
  output logic        timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0]    m_en;
  logic [2:0]    pick;
  logic [1:0]    gidx;
  logic          busy;
  logic          g_en;
  logic          wd_hit;
  logic          fire;
  logic          done_rdy;
  logic          done_err;
  logic          txn_exit;

  assign m_en = {m2_enable, m1_enable, m0_enable};

  // Round-robin winner: search starts at the master after the last one served.
  always_comb begin
    pick = '0;
    case (last_q)
      2'd0: begin
        if      (m_en[1]) pick = 3'b010;
        else if (m_en[2]) pick = 3'b100;
        else if (m_en[0]) pick = 3'b001;
      end
      2'd1: begin
        if      (m_en[2]) pick = 3'b100;
        else if (m_en[0]) pick = 3'b001;
        else if (m_en[1]) pick = 3'b010;
      end
      default: begin
        if      (m_en[0]) pick = 3'b001;
        else if (m_en[1]) pick = 3'b010;
        else if (m_en[2]) pick = 3'b100;
      end
    endcase
  end

  // Index of the currently granted master, recorded into last on exit.
  always_comb begin
    gidx = 2'd0;
    if (grant_q[1]) gidx = 2'd1;
    if (grant_q[2]) gidx = 2'd2;
  end

  // Transaction status of the granted master in the current BUSY cycle.
  // Completion only counts while the granted master still requests; a
  // dropped enable is an abort regardless of what the slave does.
  always_comb begin
    busy     = (state_q == BUSY);
    g_en     = busy & (|(grant_q & m_en));
    wd_hit   = (ENABLE_TIMEOUT != 0) && (cnt_q == CNT_LAST);
    fire     = g_en & wd_hit & ~s_ready & ~s_error;
    done_err = g_en & (s_error | fire);
    done_rdy = g_en & s_ready & ~s_error;
    txn_exit = busy & (~g_en | done_err | done_rdy);
  end

  // State, grant, round-robin pointer and watchdog counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, track completion/abort/watchdog in BUSY.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|m_en) begin
          state_d = BUSY;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (txn_exit) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: slave fields muxed from the grant while BUSY, zero in IDLE;
  // completion routed only to the granted master.
  always_comb begin
    s_address  = '0;
    s_data_o   = '0;
    s_wr       = 1'b0;
    s_byte_sel = '0;
    if (busy) begin
      s_address  = ({32{grant_q[0]}} & m0_address)
                 | ({32{grant_q[1]}} & m1_address)
                 | ({32{grant_q[2]}} & m2_address);
      s_data_o   = ({32{grant_q[0]}} & m0_data_i)
                 | ({32{grant_q[1]}} & m1_data_i)
                 | ({32{grant_q[2]}} & m2_data_i);
      s_wr       = (grant_q[0] & m0_wr)
                 | (grant_q[1] & m1_wr)
                 | (grant_q[2] & m2_wr);
      s_byte_sel = ({4{grant_q[0]}} & m0_byte_sel)
                 | ({4{grant_q[1]}} & m1_byte_sel)
                 | ({4{grant_q[2]}} & m2_byte_sel);
    end
    s_enable  = g_en & ~fire;
    m0_ready  = grant_q[0] & done_rdy;
    m1_ready  = grant_q[1] & done_rdy;
    m2_ready  = grant_q[2] & done_rdy;
    m0_error  = grant_q[0] & done_err;
    m1_error  = grant_q[1] & done_err;
    m2_error  = grant_q[2] & done_err;
    m0_data_o = s_data_i;
    m1_data_o = s_data_i;
    m2_data_o = s_data_i;
    grant     = grant_q;
    timeout   = fire;
  end

endmodule

// File: tb/tb_musb_bus_arbiter.sv
// Testbench for musb_bus_arbiter: reset checks, a table of round-robin
// vectors, hand-written corner sequences and a randomized run compared
// against a transaction-level reference model.
module tb_musb_bus_arbiter;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic [31:0] ma   [3];
  logic [31:0] md   [3];
  logic [3:0]  mbs  [3];
  logic [2:0]  mwr;
  logic [2:0]  men;
  logic [31:0] mdo  [3];
  logic [2:0]  mrdy;
  logic [2:0]  merr;
  logic [31:0] s_addr, s_do, sdi;
  logic        s_wr, s_en, srdy, serr, tmo;
  logic [3:0]  s_bs;
  logic [2:0]  grant;

  int n_cmp = 0;
  int n_bad = 0;

  musb_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ENABLE_TIMEOUT(1)) dut (
    .clk(clk), .rst(rst),
    .m0_address(ma[0]), .m0_data_i(md[0]), .m0_wr(mwr[0]), .m0_byte_sel(mbs[0]),
    .m0_enable(men[0]), .m0_data_o(mdo[0]), .m0_ready(mrdy[0]), .m0_error(merr[0]),
    .m1_address(ma[1]), .m1_data_i(md[1]), .m1_wr(mwr[1]), .m1_byte_sel(mbs[1]),
    .m1_enable(men[1]), .m1_data_o(mdo[1]), .m1_ready(mrdy[1]), .m1_error(merr[1]),
    .m2_address(ma[2]), .m2_data_i(md[2]), .m2_wr(mwr[2]), .m2_byte_sel(mbs[2]),
    .m2_enable(men[2]), .m2_data_o(mdo[2]), .m2_ready(mrdy[2]), .m2_error(merr[2]),
    .s_address(s_addr), .s_data_o(s_do), .s_wr(s_wr), .s_byte_sel(s_bs),
    .s_enable(s_en), .s_data_i(sdi), .s_ready(srdy), .s_error(serr),
    .grant(grant), .timeout(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      ma[i]  = '0;
      md[i]  = '0;
      mbs[i] = '0;
    end
    mwr  = '0;
    men  = '0;
    srdy = 1'b0;
    serr = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_grant"}, grant, 3'b000);
    chk({tag, "_s_en"}, s_en, 1'b0);
    chk({tag, "_s_addr"}, s_addr, 32'h0);
    chk({tag, "_s_do"}, s_do, 32'h0);
    chk({tag, "_s_wrbs"}, {s_wr, s_bs}, 5'h0);
    chk({tag, "_rdy"}, mrdy, 3'b000);
    chk({tag, "_err"}, merr, 3'b000);
    chk({tag, "_tmo"}, tmo, 1'b0);
  endtask

  // Reset with live-looking inputs; outputs must still show reset values.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    men   = 3'b111;
    ma[0] = 32'h1111_0000;
    md[1] = 32'h2222_0000;
    mbs[2] = 4'hF;
    srdy  = 1'b1;
    sdi   = 32'hA5A5_0F0F;
    repeat (2) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    chk("reset_mdo", {mdo[0], mdo[1]}, {sdi, sdi});
    chk("reset_mdo2", mdo[2], sdi);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          mgi;   // granted master, -1 when no transaction is open
  int          mlast;
  int          mcnt;  // BUSY cycles elapsed without completion
  logic [2:0]  e_grant, e_rdy, e_err;
  logic        e_sen, e_tmo, e_wr, ended;
  logic [31:0] e_addr, e_do;
  logic [3:0]  e_bs;

  task automatic model_eval();
    logic en, fire;
    e_grant = '0; e_rdy = '0; e_err = '0;
    e_sen = 1'b0; e_tmo = 1'b0; e_wr = 1'b0;
    e_addr = '0; e_do = '0; e_bs = '0;
    ended = 1'b0;
    if (mgi >= 0) begin
      en   = men[mgi];
      fire = en && (mcnt == TO - 1) && !srdy && !serr;
      e_grant = 3'(1 << mgi);
      e_addr  = ma[mgi];
      e_do    = md[mgi];
      e_wr    = mwr[mgi];
      e_bs    = mbs[mgi];
      e_sen   = en && !fire;
      if ((en && serr) || fire) e_err[mgi] = 1'b1;
      else if (en && srdy)      e_rdy[mgi] = 1'b1;
      e_tmo = fire;
      ended = !en || srdy || serr || fire;
    end
  endtask

  task automatic model_update();
    bit found;
    int c;
    if (mgi < 0) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        c = (mlast + k) % 3;
        if (!found && men[c]) begin
          mgi   = c;
          found = 1;
        end
      end
      mcnt = 0;
    end else if (ended) begin
      mlast = mgi;
      mgi   = -1;
    end else begin
      mcnt++;
    end
  endtask

  // ---------------- round-robin vector table ----------------
  typedef struct {
    logic [2:0] en;
    logic       rdy;
    logic [2:0] exp_grant;
    logic [2:0] exp_rdy;
    logic       exp_sen;
  } vec_t;

  vec_t tbl[8];

  logic [2:0] done_prev;
  int         stall;

  initial begin
    rst = 1'b1;
    sdi = '0;
    clear_inputs();

    // All three requesting against a zero-wait slave: m0, m1, m2, m0 ...
    tbl[0] = '{3'b111, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[1] = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b1};
    tbl[2] = '{3'b111, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[3] = '{3'b111, 1'b1, 3'b010, 3'b010, 1'b1};
    tbl[4] = '{3'b111, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[5] = '{3'b111, 1'b1, 3'b100, 3'b100, 1'b1};
    tbl[6] = '{3'b111, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[7] = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b1};

    do_reset();
    for (int v = 0; v < 8; v++) begin
      step();
      men  = tbl[v].en;
      srdy = tbl[v].rdy;
      #1;
      chk($sformatf("rr%0d_grant", v), grant, tbl[v].exp_grant);
      chk($sformatf("rr%0d_rdy", v), mrdy, tbl[v].exp_rdy);
      chk($sformatf("rr%0d_sen", v), s_en, tbl[v].exp_sen);
      chk($sformatf("rr%0d_err", v), merr, 3'b000);
    end

    // Single read from m1, slave answers two cycles after s_enable.
    do_reset();
    step(); men = 3'b010; sdi = 32'h0; #1;
    chk("rd_idle_grant", grant, 3'b000);
    chk("rd_idle_sen", s_en, 1'b0);
    step(); #1;
    chk("rd_grant", grant, 3'b010);
    chk("rd_sen", s_en, 1'b1);
    chk("rd_rdy_w0", mrdy, 3'b000);
    step(); #1;
    chk("rd_rdy_w1", mrdy, 3'b000);
    step(); srdy = 1'b1; sdi = 32'hDEAD_BEEF; #1;
    chk("rd_rdy", mrdy, 3'b010);
    chk("rd_err", merr, 3'b000);
    chk("rd_data", mdo[1], 32'hDEAD_BEEF);
    step(); srdy = 1'b0; men = 3'b000; #1;
    chk("rd_back_idle", grant, 3'b000);
    chk("rd_back_sen", s_en, 1'b0);

    // Write from m2: slave fields exact while BUSY, zero in IDLE.
    do_reset();
    step();
    ma[2] = 32'h0000_0100; md[2] = 32'h1234_5678; mbs[2] = 4'b0011;
    mwr = 3'b100; men = 3'b100; #1;
    chk("wr_idle_addr", s_addr, 32'h0);
    chk("wr_idle_data", s_do, 32'h0);
    chk("wr_idle_wrbs", {s_wr, s_bs}, 5'h0);
    step(); #1;
    chk("wr_grant", grant, 3'b100);
    chk("wr_addr", s_addr, 32'h0000_0100);
    chk("wr_data", s_do, 32'h1234_5678);
    chk("wr_wrbs", {s_wr, s_bs}, 5'b1_0011);
    step(); srdy = 1'b1; #1;
    chk("wr_rdy", mrdy, 3'b100);
    chk("wr_addr_c", s_addr, 32'h0000_0100);
    step(); srdy = 1'b0; men = 3'b000; #1;
    check_idle_outputs("wr_after");

    // Watchdog: slave never responds, error on the 8th BUSY cycle.
    do_reset();
    step(); men = 3'b010; #1;
    for (int c = 1; c <= TO; c++) begin
      step(); #1;
      if (c < TO) begin
        chk($sformatf("to_c%0d_tmo", c), tmo, 1'b0);
        chk($sformatf("to_c%0d_sen", c), s_en, 1'b1);
        chk($sformatf("to_c%0d_err", c), merr, 3'b000);
      end else begin
        chk("to_fire_tmo", tmo, 1'b1);
        chk("to_fire_err", merr, 3'b010);
        chk("to_fire_sen", s_en, 1'b0);
        chk("to_fire_rdy", mrdy, 3'b000);
      end
    end
    step(); men = 3'b100; #1;
    chk("to_after_grant", grant, 3'b000);
    chk("to_after_tmo", tmo, 1'b0);
    step(); srdy = 1'b1; #1;
    chk("to_next_grant", grant, 3'b100);
    chk("to_next_rdy", mrdy, 3'b100);
    chk("to_next_err", merr, 3'b000);
    step(); clear_inputs(); #1;

    // Slave ready and error together: error wins.
    do_reset();
    step(); men = 3'b001; #1;
    step(); srdy = 1'b1; serr = 1'b1; #1;
    chk("re_err", merr, 3'b001);
    chk("re_rdy", mrdy, 3'b000);
    step(); clear_inputs(); #1;
    chk("re_idle", grant, 3'b000);

    // Abort: m0 drops enable mid-BUSY; last still advances to m0.
    do_reset();
    step(); men = 3'b001; #1;
    step(); #1;
    chk("ab_grant", grant, 3'b001);
    step(); men = 3'b000; #1;
    chk("ab_rdy", mrdy, 3'b000);
    chk("ab_err", merr, 3'b000);
    chk("ab_sen", s_en, 1'b0);
    step(); men = 3'b111; #1;
    chk("ab_idle", grant, 3'b000);
    step(); #1;
    chk("ab_next_grant", grant, 3'b010);
    step(); clear_inputs(); #1;

    // Reset asserted in BUSY drops everything at once.
    do_reset();
    step(); men = 3'b001; ma[0] = 32'hCAFE_0004; #1;
    step(); #1;
    chk("rb_grant", grant, 3'b001);
    chk("rb_addr", s_addr, 32'hCAFE_0004);
    rst = 1'b0; srdy = 1'b1; #1;
    check_idle_outputs("rb_inrst");
    @(negedge clk);
    rst = 1'b1; srdy = 1'b0; men = 3'b111;
    step(); #1;
    chk("rb_after_grant", grant, 3'b001);
    step(); clear_inputs(); #1;

    // Randomized traffic against the reference model.
    do_reset();
    mgi = -1; mlast = 2; mcnt = 0;
    done_prev = '0;
    stall = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        if (men[i] && done_prev[i]) begin
          men[i] = 1'b0;
        end else if (men[i] && $urandom_range(0, 40) == 0) begin
          men[i] = 1'b0;
        end else if (!men[i] && $urandom_range(0, 2) == 0) begin
          men[i] = 1'b1;
          ma[i]  = $urandom;
          md[i]  = $urandom;
          mwr[i] = 1'($urandom_range(0, 1));
          mbs[i] = 4'($urandom_range(0, 15));
        end
      end
      sdi = $urandom;
      if (stall > 0) begin
        srdy = 1'b0; serr = 1'b0; stall--;
      end else if ($urandom_range(0, 24) == 0) begin
        srdy = 1'b0; serr = 1'b0; stall = 10;
      end else begin
        srdy = ($urandom_range(0, 2) == 0);
        serr = ($urandom_range(0, 9) == 0);
      end
      #1;
      model_eval();
      chk("rnd_grant", grant, e_grant);
      chk("rnd_sen", s_en, e_sen);
      chk("rnd_addr", s_addr, e_addr);
      chk("rnd_sdo", s_do, e_do);
      chk("rnd_wrbs", {s_wr, s_bs}, {e_wr, e_bs});
      chk("rnd_rdy", mrdy, e_rdy);
      chk("rnd_err", merr, e_err);
      chk("rnd_tmo", tmo, e_tmo);
      chk("rnd_mdo", mdo[cyc % 3], sdi);
      done_prev = e_rdy | e_err;
      model_update();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
